// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and the 3-sample vote for the UART receiver.
package uart_pkg;

    localparam int unsigned PARITY_NONE          = 0;
    localparam int unsigned PARITY_ODD           = 1;
    localparam int unsigned PARITY_EVEN          = 2;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;  // 50 MHz / 9600 baud

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_sampler.sv
// Per-bit baud counter with three mid-bit samples; the vote is resolved on the bit tick.
module uart_baud_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_rx_s,
    output logic o_bit_tick_c,
    output logic o_bit_val_c,
    output logic o_wrap_c
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned     HALF     = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_samp_a;
    logic             r_samp_b;

    // Counter is held at zero while idle so a start edge always begins at cnt=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else begin
            if (!i_run || (r_cnt == CNT_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cnt == SAMP_A) r_samp_a <= i_rx_s;
            if (r_cnt == SAMP_B) r_samp_b <= i_rx_s;
        end
    end

    assign o_bit_tick_c = i_run && (r_cnt == SAMP_C);
    assign o_wrap_c     = i_run && (r_cnt == CNT_LAST);
    assign o_bit_val_c  = maj3(r_samp_a, r_samp_b, i_rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver feeding the instruction-memory loader through a
// one-entry valid/ready buffer, with sticky error flags and a load-address counter.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_uart_rx,
    input  logic                  i_rx_ready,
    input  logic                  i_err_clr,
    output logic [DATA_BITS-1:0]  o_rx_data,
    output logic                  o_rx_valid,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic                  o_busy,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun_err
);

    localparam int unsigned  BCW        = 4;
    localparam logic [BCW-1:0] BITS_LAST = BCW'(DATA_BITS);
    localparam logic         STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic         ODD_INV    = 1'(PARITY_MODE == PARITY_ODD);
    localparam logic         HAS_PARITY = 1'(PARITY_MODE != PARITY_NONE);

    rx_state_t             r_state, w_state_nxt;
    logic                  r_sync1, r_rx_s, r_rx_prev;
    logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
    logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_stop_cnt, w_stop_cnt_nxt;
    logic                  r_bad_par, w_bad_par_nxt;
    logic                  r_bad_frm, w_bad_frm_nxt;
    logic                  r_done, w_done_nxt;
    logic [DATA_BITS-1:0]  r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_parity_err, w_parity_err_nxt;
    logic                  r_frame_err, w_frame_err_nxt;
    logic                  r_overrun_err, w_overrun_err_nxt;
    logic                  w_bit_tick, w_bit_val, w_wrap;
    logic                  w_xfer, w_good, w_load;

    uart_baud_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (r_state != ST_IDLE),
        .i_rx_s       (r_rx_s),
        .o_bit_tick_c (w_bit_tick),
        .o_bit_val_c  (w_bit_val),
        .o_wrap_c     (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sync1       <= 1'b1;
            r_rx_s        <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_stop_cnt    <= 1'b0;
            r_bad_par     <= 1'b0;
            r_bad_frm     <= 1'b0;
            r_done        <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_addr        <= '0;
            r_busy        <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sync1       <= i_uart_rx;
            r_rx_s        <= r_sync1;
            r_rx_prev     <= r_rx_s;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_stop_cnt    <= w_stop_cnt_nxt;
            r_bad_par     <= w_bad_par_nxt;
            r_bad_frm     <= w_bad_frm_nxt;
            r_done        <= w_done_nxt;
            r_rx_data     <= w_rx_data_nxt;
            r_rx_valid    <= w_rx_valid_nxt;
            r_addr        <= w_addr_nxt;
            r_busy        <= w_busy_nxt;
            r_parity_err  <= w_parity_err_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_overrun_err <= w_overrun_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_bad_par_nxt  = r_bad_par;
        w_bad_frm_nxt  = r_bad_frm;
        w_done_nxt     = 1'b0;

        unique case (r_state)
            // A held-low line never shows a 1->0 edge, so a break cannot restart a frame.
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_state_nxt    = ST_START;
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = 1'b0;
                    w_bad_par_nxt  = 1'b0;
                    w_bad_frm_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_tick && w_bit_val) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_shift_nxt   = {w_bit_val, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                end
                if (w_wrap && (r_bit_cnt == BITS_LAST)) begin
                    w_state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_bad_par_nxt = (w_bit_val != ((^r_shift) ^ ODD_INV));
                end
                if (w_wrap) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    if (!w_bit_val) w_bad_frm_nxt = 1'b1;
                    if (r_stop_cnt == STOP_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Completion and handshake act one cycle after the last stop tick.
        w_xfer            = r_rx_valid & i_rx_ready;
        w_good            = r_done & ~r_bad_par & ~r_bad_frm;
        w_load            = w_good & (~r_rx_valid | i_rx_ready);
        w_rx_data_nxt     = w_load ? r_shift : r_rx_data;
        w_rx_valid_nxt    = w_load | (r_rx_valid & ~i_rx_ready);
        w_addr_nxt        = r_addr + ADDR_WIDTH'(w_xfer);
        w_busy_nxt        = (w_state_nxt != ST_IDLE);
        w_parity_err_nxt  = (r_done & r_bad_par) | (r_parity_err & ~i_err_clr);
        w_frame_err_nxt   = (r_done & r_bad_frm) | (r_frame_err & ~i_err_clr);
        w_overrun_err_nxt = (w_good & r_rx_valid & ~i_rx_ready) | (r_overrun_err & ~i_err_clr);
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_data_addr   = r_addr;
    assign o_busy        = r_busy;
    assign o_parity_err  = r_parity_err;
    assign o_frame_err   = r_frame_err;
    assign o_overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (2-bit address) and an 8E2 instance,
// driven with serial frames and checked against a queue-based transfer model.
module tb_uart_rx_param;

    localparam int unsigned CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx0, rdy0, clr0, val0, busy0, pe0, fe0, oe0;
    logic [7:0]  data0;
    logic [1:0]  addr0;
    logic        rx1, rdy1, clr1, val1, busy1, pe1, fe1, oe1;
    logic [7:0]  data1;
    logic [15:0] addr1;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned n_xfer0 = 0;
    int unsigned n_xfer1 = 0;
    int unsigned n_vcyc0 = 0;
    int unsigned m_addr0 = 0;
    int unsigned m_addr1 = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                    .STOP_BITS(1), .ADDR_WIDTH(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx0), .i_rx_ready(rdy0), .i_err_clr(clr0),
        .o_rx_data(data0), .o_rx_valid(val0), .o_data_addr(addr0), .o_busy(busy0),
        .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun_err(oe0)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                    .STOP_BITS(2), .ADDR_WIDTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx1), .i_rx_ready(rdy1), .i_err_clr(clr1),
        .o_rx_data(data1), .o_rx_valid(val1), .o_data_addr(addr1), .o_busy(busy1),
        .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun_err(oe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_rx(input int idx, input logic v);
        if (idx == 0) rx0 = v;
        else          rx1 = v;
    endtask

    // Builds the frame bit list; glitch_bit >= 0 inverts one cycle at the centre of that data bit.
    task automatic send_frame(input int idx, input logic [7:0] d, input bit par_ok,
                              input bit stop_ok, input int glitch_bit);
        logic [11:0] bits;
        int          n;
        logic        v;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (idx == 1) begin
            bits[9] = (^d) ^ (par_ok ? 1'b0 : 1'b1);
            n = 10;
        end
        for (int s = 0; s < ((idx == 1) ? 2 : 1); s++) begin
            bits[n] = stop_ok ? 1'b1 : 1'b0;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                v = bits[b];
                if ((b == glitch_bit + 1) && (c == 9)) v = ~v;
                drive_rx(idx, v);
                tick(1);
            end
        end
        drive_rx(idx, 1'b1);
        tick(4);
    endtask

    task automatic pulse_clr(input int idx);
        if (idx == 0) clr0 = 1'b1; else clr1 = 1'b1;
        tick(1);
        if (idx == 0) clr0 = 1'b0; else clr1 = 1'b0;
        tick(1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_data0", 32'(data0), 0);  chk("rst_val0", 32'(val0), 0);
        chk("rst_addr0", 32'(addr0), 0);  chk("rst_busy0", 32'(busy0), 0);
        chk("rst_err0", 32'({pe0, fe0, oe0}), 0);
        chk("rst_data1", 32'(data1), 0);  chk("rst_val1", 32'(val1), 0);
        chk("rst_addr1", 32'(addr1), 0);  chk("rst_busy1", 32'(busy1), 0);
        chk("rst_err1", 32'({pe1, fe1, oe1}), 0);
    endtask

    // Transfer monitors: each accepted byte must be the oldest expected one, at the model address.
    always @(negedge clk) begin
        if (rst_n) begin
            if (val0) n_vcyc0++;
            if (val0 && rdy0) begin
                n_xfer0++;
                if (q0.size() == 0) chk("xfer0_unexpected", 1, 0);
                else                chk("xfer0_data", 32'(data0), 32'(q0.pop_front()));
                chk("xfer0_addr", 32'(addr0), m_addr0);
                m_addr0 = (m_addr0 + 1) % 4;
            end
            if (val1 && rdy1) begin
                n_xfer1++;
                if (q1.size() == 0) chk("xfer1_unexpected", 1, 0);
                else                chk("xfer1_data", 32'(data1), 32'(q1.pop_front()));
                chk("xfer1_addr", 32'(addr1), m_addr1);
                m_addr1 = (m_addr1 + 1) % 65536;
            end
        end
    end

    initial begin
        int unsigned xs;
        logic [7:0]  d;
        bit          ok;

        rst_n = 1'b0;
        rx0 = 1'b1; rdy0 = 1'b1; clr0 = 1'b0;
        rx1 = 1'b1; rdy1 = 1'b1; clr1 = 1'b0;
        tick(3);
        chk_reset_outputs();
        rst_n = 1'b1;
        tick(5);

        // Basic 8N1 byte with the consumer ready
        q0.push_back(8'hA5);
        send_frame(0, 8'hA5, 1, 1, -1);
        chk("t1_valid_cycles", n_vcyc0, 1);
        chk("t1_data", 32'(data0), 32'hA5);
        chk("t1_addr", 32'(addr0), 1);
        chk("t1_flags", 32'({pe0, fe0, oe0}), 0);
        chk("t1_busy", 32'(busy0), 0);

        // Random good bytes; six more bytes take the 2-bit address through a wrap
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            q0.push_back(d);
            send_frame(0, d, 1, 1, -1);
            chk("rnd0_addr", 32'(addr0), m_addr0);
        end
        chk("rnd0_addr_final", 32'(addr0), 32'((1 + 6) % 4));

        // Even-parity instance: random bytes, about a quarter with a bad parity bit
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            if (ok) q1.push_back(d);
            xs = m_addr1;
            send_frame(1, d, ok, 1, -1);
            chk("rnd1_perr", 32'(pe1), ok ? 0 : 1);
            chk("rnd1_addr", 32'(addr1), ok ? xs + 1 : xs);
            chk("rnd1_ferr", 32'(fe1), 0);
            if (pe1) pulse_clr(1);
        end

        // Wrong even-parity bit on 0x07: byte dropped, sticky flag until cleared
        xs = m_addr1;
        send_frame(1, 8'h07, 0, 1, -1);
        chk("t2_valid", 32'(val1), 0);
        chk("t2_perr", 32'(pe1), 1);
        chk("t2_addr", 32'(addr1), xs);
        pulse_clr(1);
        chk("t2_perr_clr", 32'(pe1), 0);

        // Overrun: second byte dropped while the first is unread
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 1, 1, -1);
        chk("t3_valid_a", 32'(val0), 1);
        chk("t3_data_a", 32'(data0), 32'h11);
        chk("t3_oerr_a", 32'(oe0), 0);
        send_frame(0, 8'h22, 1, 1, -1);
        chk("t3_valid_b", 32'(val0), 1);
        chk("t3_data_b", 32'(data0), 32'h11);
        chk("t3_oerr_b", 32'(oe0), 1);
        q0.push_back(8'h11);
        xs = n_xfer0;
        rdy0 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
        tick(3);
        chk("t3_one_xfer", n_xfer0, xs + 1);
        chk("t3_valid_c", 32'(val0), 0);
        chk("t3_addr", 32'(addr0), m_addr0);
        pulse_clr(0);
        chk("t3_oerr_clr", 32'(oe0), 0);
        rdy0 = 1'b1;

        // Short low glitch: false start, nothing reported
        xs = n_xfer0;
        rx0 = 1'b0;
        tick(4);
        rx0 = 1'b1;
        tick(4);
        chk("t4_busy_start", 32'(busy0), 1);
        tick(3 * CPB);
        chk("t4_busy_end", 32'(busy0), 0);
        chk("t4_no_xfer", n_xfer0, xs);
        chk("t4_flags", 32'({pe0, fe0, oe0}), 0);

        // Stop bit low on 0x3C, then a mid-bit glitch the vote must absorb
        xs = m_addr0;
        send_frame(0, 8'h3C, 1, 0, -1);
        chk("t5_ferr", 32'(fe0), 1);
        chk("t5_valid", 32'(val0), 0);
        chk("t5_addr", 32'(addr0), xs);
        pulse_clr(0);
        chk("t5_ferr_clr", 32'(fe0), 0);
        q0.push_back(8'h3C);
        send_frame(0, 8'h3C, 1, 1, 2);
        chk("t5_glitch_data", 32'(data0), 32'h3C);
        chk("t5_glitch_flags", 32'({pe0, fe0, oe0}), 0);

        // Break: a single frame error, then no new frames while the line stays low
        rx0 = 1'b0;
        tick(30 * CPB);
        chk("brk_ferr", 32'(fe0), 1);
        chk("brk_busy", 32'(busy0), 0);
        pulse_clr(0);
        tick(20 * CPB);
        chk("brk_ferr_once", 32'(fe0), 0);
        chk("brk_busy_hold", 32'(busy0), 0);
        rx0 = 1'b1;
        tick(20);
        d = 8'($urandom);
        q0.push_back(d);
        send_frame(0, d, 1, 1, -1);
        chk("brk_recover_data", 32'(data0), 32'(d));

        // Reset during the data bits, held until the abandoned frame has passed
        fork
            send_frame(0, 8'hC3, 1, 1, -1);
            begin
                tick(4 * CPB);
                rst_n = 1'b0;
                tick(2);
                chk_reset_outputs();
            end
        join
        q0.delete();
        q1.delete();
        m_addr0 = 0;
        m_addr1 = 0;
        rst_n = 1'b1;
        tick(5);
        q0.push_back(8'h5A);
        send_frame(0, 8'h5A, 1, 1, -1);
        chk("t6_data", 32'(data0), 32'h5A);
        chk("t6_addr", 32'(addr0), 1);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            q0.push_back(d);
            send_frame(0, d, 1, 1, -1);
        end
        chk("t6_addr_wrap", 32'(addr0), 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
